// File: rtl/instr_fetch_unit_pkg.sv
// fetch_pkg: shared state encoding, constants and instruction field positions for the fetch stage
package fetch_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    // addi x0,x0,0: presented whenever no live instruction is held
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    // instruction addresses must be word aligned
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory valid/ready request and valid-only response channel
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// fetch_pc_reg: program counter with load-redirect / increment-by-4 / hold selection
module fetch_pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    // wraps modulo 2^XLEN
    assign pc_plus4 = pc + XLEN'(4);

    // a redirect load wins over sequential advance; otherwise the PC holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (load)
            pc <= load_pc;
        else if (inc)
            pc <= pc_plus4;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-issue fetch stage holding the PC, one outstanding imem request and the decoded word
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_unit_if.master    imem,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  stall,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [XLEN-1:0]       instr_pc,
    output logic [XLEN-1:0]       pc_plus4,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic                  fetch_fault
);
    fetch_state_t    state, state_nxt;
    logic            fault_pend, fault_pend_nxt;
    logic [XLEN-1:0] pc, pc_next4;
    logic            redir, in_flight, outstanding, capture, consume, mis;

    // a faulted stage ignores redirects until reset
    assign redir       = redirect_valid && state != FAULT;
    assign mis         = misaligned(redirect_pc[1:0]);
    assign in_flight   = state == WAIT || state == DRAIN;
    // a response is still owed if one is accepted now or one is pending and not arriving this cycle
    assign outstanding = (state == FETCH && imem.req_ready) || (in_flight && !imem.rsp_valid);
    assign capture     = state == WAIT && imem.rsp_valid && !redir;
    assign consume     = state == HOLD && !stall;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (redir),
        .inc      (consume && !redir),
        .load_pc  (redirect_pc),
        .pc       (pc),
        .pc_plus4 (pc_next4)
    );

    // next state: redirect first, then the normal request/response/consume progression
    always_comb begin
        state_nxt      = state;
        fault_pend_nxt = fault_pend;
        if (redir) begin
            fault_pend_nxt = mis;
            state_nxt      = outstanding ? DRAIN : (mis ? FAULT : FETCH);
        end else begin
            case (state)
                FETCH:   if (imem.req_ready) state_nxt = WAIT;
                WAIT:    if (imem.rsp_valid) state_nxt = HOLD;
                HOLD:    if (!stall) state_nxt = FETCH;
                DRAIN:   if (imem.rsp_valid) state_nxt = fault_pend ? FAULT : FETCH;
                default: state_nxt = state;
            endcase
        end
    end

    // state and the deferred-fault flag that is honoured once a drain completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            fault_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            fault_pend <= fault_pend_nxt;
        end
    end

    // capture the returned word with its PC and link address; fall back to NOP when it leaves HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            instr_pc <= RESET_PC;
            pc_plus4 <= RESET_PC + XLEN'(4);
        end else if (capture) begin
            instr    <= imem.rsp_data;
            instr_pc <= pc;
            pc_plus4 <= pc_next4;
        end else if (state == HOLD && (redir || !stall)) begin
            instr    <= NOP_INSTR;
        end
    end

    assign imem.req_valid = state == FETCH;
    assign imem.req_addr  = pc;
    assign instr_valid    = state == HOLD;
    assign fetch_fault    = state == FAULT;

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign funct3 = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign rs1    = instr[RS1_MSB:RS1_LSB];
    assign rs2    = instr[RS2_MSB:RS2_LSB];
    assign funct7 = instr[FUNCT7_MSB:FUNCT7_LSB];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, directed corner sequences and a randomized run against a transaction-level model
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        instr_valid, fetch_fault;
    logic [31:0] instr, instr_pc, pc_plus4;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    int passed = 0;
    int total  = 0;

    instr_fetch_unit_if #(.XLEN(32)) imem ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, rv;
        logic [31:0] dat;
        logic        rdr;
        logic [31:0] rpc;
        logic        stl;
        logic        erv;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] einstr, eipc;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rdy_i, rv_i, input logic [31:0] dat_i, input logic rdr_i,
                               input logic [31:0] rpc_i, input logic stl_i, erv_i, input logic [31:0] eaddr_i,
                               input logic eiv_i, input logic [31:0] einstr_i, eipc_i, input logic ef_i);
        vec_t r;
        r.rdy = rdy_i; r.rv = rv_i; r.dat = dat_i; r.rdr = rdr_i; r.rpc = rpc_i; r.stl = stl_i;
        r.erv = erv_i; r.eaddr = eaddr_i; r.eiv = eiv_i; r.einstr = einstr_i; r.eipc = eipc_i; r.ef = ef_i;
        return r;
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0013_5A93;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic erv, input logic [31:0] eaddr, input logic eiv,
                           input logic [31:0] einstr, eipc, input logic ef);
        chk({tag, " req_valid"}, imem.req_valid, erv);
        if (erv) chk({tag, " req_addr"}, imem.req_addr, eaddr);
        chk({tag, " instr_valid"}, instr_valid, eiv);
        chk({tag, " instr"}, instr, einstr);
        chk({tag, " fetch_fault"}, fetch_fault, ef);
        chk({tag, " opcode"}, opcode, einstr[6:0]);
        chk({tag, " rd"}, rd, einstr[11:7]);
        chk({tag, " funct3"}, funct3, einstr[14:12]);
        chk({tag, " rs1"}, rs1, einstr[19:15]);
        chk({tag, " rs2"}, rs2, einstr[24:20]);
        chk({tag, " funct7"}, funct7, einstr[31:25]);
        if (eiv) begin
            chk({tag, " instr_pc"}, instr_pc, eipc);
            chk({tag, " pc_plus4"}, pc_plus4, eipc + 32'd4);
        end
    endtask

    task automatic set_in(input logic rdy_i, rv_i, input logic [31:0] dat_i, input logic rdr_i,
                          input logic [31:0] rpc_i, input logic stl_i);
        imem.req_ready = rdy_i;
        imem.rsp_valid = rv_i;
        imem.rsp_data  = dat_i;
        redirect_valid = rdr_i;
        redirect_pc    = rpc_i;
        stall          = stl_i;
    endtask

    // transaction-level reference: PC, whether a word is held, whether a response is owed and if it is stale
    logic [31:0] m_pc, m_word, m_ipc, mem_addr, rpc;
    logic        m_have, m_out, m_stale, m_fault, m_fpend, mem_busy;
    logic        rdy, stl, rdr, rspv, acc, got, erv;
    int          mem_lat;

    task automatic model_reset;
        m_pc = 32'h0; m_word = NOP_INSTR; m_ipc = 32'h0;
        m_have = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_fault = 1'b0; m_fpend = 1'b0;
        mem_busy = 1'b0; mem_lat = 0; mem_addr = 32'h0;
    endtask

    initial begin
        localparam logic [31:0] N = NOP_INSTR;
        vecs.push_back(v(1, 0, 0,            0, 0,            0, 1, 0,            0, N,            0,            0));
        vecs.push_back(v(0, 1, 32'h00500093, 0, 0,            0, 0, 0,            0, N,            0,            0));
        vecs.push_back(v(0, 0, 0,            0, 0,            0, 0, 0,            1, 32'h00500093, 0,            0));
        vecs.push_back(v(1, 0, 0,            0, 0,            0, 1, 4,            0, N,            0,            0));
        vecs.push_back(v(0, 1, 32'h00108113, 0, 0,            0, 0, 0,            0, N,            0,            0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(1, 0, 0,        0, 0,            1, 0, 0,            1, 32'h00108113, 4,            0));
        vecs.push_back(v(1, 0, 0,            0, 0,            0, 0, 0,            1, 32'h00108113, 4,            0));
        vecs.push_back(v(1, 0, 0,            1, 32'h100,      0, 1, 8,            0, N,            0,            0));
        vecs.push_back(v(1, 1, 32'hDEADBEEF, 0, 0,            0, 0, 0,            0, N,            0,            0));
        vecs.push_back(v(0, 0, 0,            0, 0,            0, 1, 32'h100,      0, N,            0,            0));
        vecs.push_back(v(1, 0, 0,            0, 0,            0, 1, 32'h100,      0, N,            0,            0));
        vecs.push_back(v(0, 1, 32'h002081B3, 0, 0,            0, 0, 0,            0, N,            0,            0));
        vecs.push_back(v(0, 0, 0,            1, 32'h200,      1, 0, 0,            1, 32'h002081B3, 32'h100,      0));
        vecs.push_back(v(1, 0, 0,            0, 0,            0, 1, 32'h200,      0, N,            0,            0));
        vecs.push_back(v(0, 1, 32'h12345678, 1, 32'hFFFFFFFC, 0, 0, 0,            0, N,            0,            0));
        vecs.push_back(v(1, 0, 0,            0, 0,            0, 1, 32'hFFFFFFFC, 0, N,            0,            0));
        vecs.push_back(v(0, 1, 32'h00000073, 0, 0,            0, 0, 0,            0, N,            0,            0));
        vecs.push_back(v(0, 0, 0,            0, 0,            0, 0, 0,            1, 32'h00000073, 32'hFFFFFFFC, 0));
        vecs.push_back(v(0, 0, 0,            1, 32'h102,      0, 1, 0,            0, N,            0,            0));
        vecs.push_back(v(1, 0, 0,            1, 32'h300,      0, 0, 0,            0, N,            0,            1));
        vecs.push_back(v(1, 0, 0,            0, 0,            0, 0, 0,            0, N,            0,            1));

        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b0);
        chk("reset instr_pc", instr_pc, 32'h0);
        chk("reset pc_plus4", pc_plus4, 32'h4);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            chk_out($sformatf("vec%0d", i), vecs[i].erv, vecs[i].eaddr, vecs[i].eiv, vecs[i].einstr, vecs[i].eipc, vecs[i].ef);
            set_in(vecs[i].rdy, vecs[i].rv, vecs[i].dat, vecs[i].rdr, vecs[i].rpc, vecs[i].stl);
            step;
        end
        set_in(0, 0, 0, 0, 0, 0);

        // reset clears a sticky fault and restarts fetching at the reset PC
        rst_n = 1'b0;
        #1;
        chk("fault_rst fetch_fault", fetch_fault, 1'b0);
        chk("fault_rst instr", instr, NOP_INSTR);
        @(negedge clk);
        rst_n = 1'b1;
        chk("fault_rst req_valid", imem.req_valid, 1'b1);
        chk("fault_rst req_addr", imem.req_addr, 32'h0);

        // asynchronous reset while a request is outstanding
        set_in(0, 0, 0, 1, 32'h40, 0);
        step;
        set_in(0, 0, 0, 0, 0, 0);
        chk("wrst redirect addr", imem.req_addr, 32'h40);
        set_in(1, 0, 0, 0, 0, 0);
        step;
        set_in(0, 1, 32'h00A00513, 0, 0, 0);
        step;
        set_in(0, 0, 0, 0, 0, 0);
        chk("wrst instr_pc", instr_pc, 32'h40);
        chk("wrst pc_plus4", pc_plus4, 32'h44);
        step;
        chk("wrst next addr", imem.req_addr, 32'h44);
        set_in(1, 0, 0, 0, 0, 0);
        step;
        set_in(0, 0, 0, 0, 0, 0);
        chk("wrst in wait", imem.req_valid, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("wrst async", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b0);
        chk("wrst instr_pc", instr_pc, 32'h0);
        chk("wrst pc_plus4", pc_plus4, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 1, 32'hFFFFFFFF, 0, 0, 0);
        step;
        set_in(0, 0, 0, 0, 0, 0);
        chk_out("wrst stray rsp", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b0);

        // misaligned redirect with a request in flight: fault only after the drain
        set_in(1, 0, 0, 1, 32'h102, 0);
        step;
        set_in(0, 0, 0, 0, 0, 0);
        chk_out("mdrain draining", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b0);
        step;
        chk_out("mdrain waiting", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b0);
        set_in(1, 1, 32'h00000013, 0, 0, 0);
        step;
        set_in(1, 0, 0, 0, 0, 0);
        chk_out("mdrain faulted", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b1);
        step;
        chk_out("mdrain sticky", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 1'b1);

        // randomized run against the reference model, with occasional asynchronous resets
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            erv = !m_fault && !m_have && !m_out;
            chk_out("rnd", erv, m_pc, m_have, m_have ? m_word : NOP_INSTR, m_ipc, m_fault);
            if ($urandom_range(0, 299) == 0 || (m_fault && $urandom_range(0, 19) == 0)) begin
                set_in(0, 0, 0, 0, 0, 0);
                rst_n = 1'b0;
                #1;
                chk("rnd rst instr_valid", instr_valid, 1'b0);
                chk("rnd rst fetch_fault", fetch_fault, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                continue;
            end
            rdy  = $urandom_range(0, 2) != 0;
            stl  = $urandom_range(0, 3) == 0;
            rdr  = $urandom_range(0, 9) == 0;
            rpc  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
            if ($urandom_range(0, 11) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            rspv = mem_busy && mem_lat == 0;
            set_in(rdy, rspv, memf(mem_addr), rdr, rpc, stl);
            if (rspv) mem_busy = 1'b0;
            else if (mem_busy) mem_lat--;
            if (imem.req_valid && rdy) begin
                mem_busy = 1'b1;
                mem_addr = imem.req_addr;
                mem_lat  = $urandom_range(0, 2);
            end
            acc = erv && rdy;
            got = m_out && rspv;
            if (!m_fault) begin
                if (rdr) begin
                    m_pc    = rpc;
                    m_have  = 1'b0;
                    m_fpend = rpc[1:0] != 2'b00;
                    if (acc) begin
                        m_out = 1'b1;
                        m_stale = 1'b1;
                    end else if (m_out && !got) m_stale = 1'b1;
                    else m_out = 1'b0;
                    if (!m_out && m_fpend) m_fault = 1'b1;
                end else begin
                    if (acc) begin
                        m_out = 1'b1;
                        m_stale = 1'b0;
                    end
                    if (got) begin
                        m_out = 1'b0;
                        if (!m_stale) begin
                            m_have = 1'b1;
                            m_word = memf(mem_addr);
                            m_ipc  = m_pc;
                        end else if (m_fpend) m_fault = 1'b1;
                    end else if (m_have && !stl) begin
                        m_have = 1'b0;
                        m_pc   = m_pc + 32'd4;
                    end
                end
            end
            if (got && !rdr && !m_stale) chk("rnd word matches its address", imem.rsp_data, memf(m_pc));
            step;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
